// File: rtl/instr_bus_router.sv
`default_nettype none
// ============================================================================
// Module      : instr_bus_router
// Description : Instruction-bus router between one core fetch port and
//               N_SLAVES memory slaves. Requests are decoded by base/mask and
//               forwarded to the lowest-index matching slave. Accepted fetch
//               IDs are kept in an in-order FIFO (MAX_OUTST deep), and
//               responses are steered back from the slave at the FIFO head.
//               Optional decode-error responses are enabled by the macro
//               INSTR_BUS_ROUTER_DECERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_bus_router #(
    parameter int N_SLAVES  = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 2,
    parameter logic [N_SLAVES-1:0][ADDR_W-1:0] SLAVE_BASE = {32'h0001_0000, 32'h0000_0000},
    parameter logic [N_SLAVES-1:0][ADDR_W-1:0] SLAVE_MASK = {32'hFFFF_0000, 32'hFFFF_F000},
    parameter logic [DATA_W-1:0] ERR_RDATA = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             core_req,
    input  logic [ADDR_W-1:0]                core_addr,
    output logic                             core_gnt,
    output logic                             core_rvalid,
    output logic [DATA_W-1:0]                core_rdata,
    output logic                             core_rerr,
    output logic [N_SLAVES-1:0]              s_req,
    output logic [N_SLAVES*ADDR_W-1:0]       s_addr,
    input  logic [N_SLAVES-1:0]              s_gnt,
    input  logic [N_SLAVES-1:0]              s_rvalid,
    input  logic [N_SLAVES*DATA_W-1:0]       s_rdata,
    output logic [$clog2(MAX_OUTST+1)-1:0]   pending_cnt,
    output logic                             proto_err
);

    // ID N_SLAVES is reserved for decode-error entries.
    localparam int c_id_w  = $clog2(N_SLAVES + 1);
    localparam int c_ptr_w = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int c_cnt_w = $clog2(MAX_OUTST + 1);
    localparam logic [c_id_w-1:0]  c_err_id   = c_id_w'(N_SLAVES);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(MAX_OUTST - 1);
    localparam logic [c_cnt_w-1:0] c_max_cnt  = c_cnt_w'(MAX_OUTST);

    // FIFO state
    logic [c_id_w-1:0]  r_fifo [MAX_OUTST];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_proto_err;

    // Decode / steering wires
    logic [N_SLAVES-1:0] w_hit;
    logic [N_SLAVES-1:0] w_sel_oh;
    logic [c_id_w-1:0]   w_sel_id;
    logic                w_miss;
    logic                w_empty;
    logic [c_id_w-1:0]   w_head_id;
    logic [N_SLAVES-1:0] w_head_oh;
    logic                w_rvalid;
    logic [DATA_W-1:0]   w_rdata;
    logic                w_rerr;
    logic                w_pop;
    logic                w_can_push;
    logic                w_gnt;
    logic                w_accept;
    logic [c_id_w-1:0]   w_push_id;

    // Address match per slave region
    generate
        for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_decode
            assign w_hit[gi] = ((core_addr & SLAVE_MASK[gi]) == SLAVE_BASE[gi]);
        end
    endgenerate

    // Lowest matching index wins; no match is a miss
    always_comb begin
        w_sel_oh = '0;
        w_sel_id = '0;
        w_miss   = 1'b1;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_sel_oh = '0;
                w_sel_oh[i] = 1'b1;
                w_sel_id = c_id_w'(i);
                w_miss   = 1'b0;
            end
        end
    end

    assign w_empty   = (r_cnt == '0);
    assign w_head_id = r_fifo[r_rd_ptr];

    // One-hot of the slave whose response is currently expected (none when empty)
    always_comb begin
        w_head_oh = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            w_head_oh[i] = !w_empty && (w_head_id == c_id_w'(i));
        end
    end

    // Response steering from the FIFO head
    always_comb begin
        w_rvalid = 1'b0;
        w_rdata  = '0;
        w_rerr   = 1'b0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (w_head_oh[i]) begin
                w_rvalid = s_rvalid[i];
                w_rdata  = s_rdata[i*DATA_W +: DATA_W];
            end
        end
`ifdef INSTR_BUS_ROUTER_DECERR_EN
        // A decode-error entry answers itself as soon as it reaches the head.
        if (!w_empty && (w_head_id == c_err_id)) begin
            w_rvalid = 1'b1;
            w_rdata  = ERR_RDATA;
            w_rerr   = 1'b1;
        end
`endif
    end

    assign w_pop      = w_rvalid;
    // A full FIFO still accepts when the head is retiring in the same cycle.
    assign w_can_push = (r_cnt < c_max_cnt) | w_pop;

    // Grant is combinational from the selected slave; held low during reset
    always_comb begin
        w_gnt = 1'b0;
        if (rst_n) begin
            if (!w_miss) begin
                w_gnt = |(s_gnt & w_sel_oh) & w_can_push;
            end
`ifdef INSTR_BUS_ROUTER_DECERR_EN
            else begin
                w_gnt = w_can_push;
            end
`endif
        end
    end

    assign w_accept  = core_req & w_gnt;
    assign w_push_id = w_miss ? c_err_id : w_sel_id;

    // Per-slave request/address forwarding; unselected slaves see zeros
    generate
        for (genvar gs = 0; gs < N_SLAVES; gs++) begin : g_fwd
            assign s_req[gs] = rst_n & w_sel_oh[gs] & core_req & w_can_push;
            assign s_addr[gs*ADDR_W +: ADDR_W] = (rst_n && w_sel_oh[gs]) ? core_addr : '0;
        end
    endgenerate

    // FIFO pointers and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_accept && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_accept && w_pop) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // FIFO storage: entries are only meaningful between push and pop, no reset needed
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_fifo[r_wr_ptr] <= w_push_id;
        end
    end

    // Flag any response that does not come from the expected head slave
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_proto_err <= 1'b0;
        end else begin
            r_proto_err <= |(s_rvalid & ~w_head_oh);
        end
    end

`ifndef INSTR_BUS_ROUTER_DECERR_EN
    // Warn when the core keeps requesting an unmapped address (it will stall)
    always @(negedge clk) begin
        if (rst_n) begin
            assert (!(core_req && w_miss))
                else $warning("instr_bus_router: core_req held on unmapped address %h", core_addr);
        end
    end
`endif

    assign core_gnt    = w_gnt;
    assign core_rvalid = w_rvalid;
    assign core_rdata  = w_rdata;
    assign core_rerr   = w_rerr;
    assign pending_cnt = r_cnt;
    assign proto_err   = r_proto_err;

endmodule
`default_nettype wire
